// File: rtl/multi_ch_frame_tx.sv
// Multi-channel snapshot framer: latches N_CH words on a host command and streams them as framed LE bytes.
// Optional trailing modulo-256 payload checksum when FRAME_CSUM_EN is defined.
module multi_ch_frame_tx #(
    parameter int          N_CH     = 16,
    parameter int          DATA_W   = 16,
    parameter logic [7:0]  CMD_SNAP = 8'hFF,
    parameter logic [7:0]  CMD_CONT = 8'hFE,
    parameter logic [7:0]  CMD_STOP = 8'h00
) (
    input  logic                   CLK_50M,
    input  logic                   RESET,
    input  logic [N_CH*DATA_W-1:0] DATA_IN,
    input  logic [7:0]             RX_DATA,
    input  logic                   RX_VALID,
    output logic [7:0]             TX_DATA,
    output logic                   TX_REQ,
    input  logic                   TX_IDLE,
    output logic                   BUSY,
    output logic                   CONT_MODE,
    output logic [7:0]             FRAME_SEQ
);

`ifdef FRAME_CSUM_EN
    localparam int CSUM_LEN = 1;
`else
    localparam int CSUM_LEN = 0;
`endif
    localparam int PAY_LEN   = N_CH * DATA_W / 8;
    localparam int FRAME_LEN = 4 + PAY_LEN + CSUM_LEN;
    localparam int IDX_W     = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0] HDR_LEN  = IDX_W'(4);

    typedef enum logic [2:0] {
        S_IDLE, S_LATCH, S_LOAD, S_REQ, S_GAP, S_WAIT, S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [N_CH*DATA_W-1:0] snap_q, snap_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic [7:0]             seq_q, seq_d;
    logic                   busy_q, busy_d;
    logic                   cont_q, cont_d;
    logic                   pend_q, pend_d;
`ifdef FRAME_CSUM_EN
    logic [7:0]             csum_q, csum_d;
`endif
    logic [IDX_W-1:0]       pay_idx;
    logic [7:0]             cur_byte;

    // Channel k sits at bit k*DATA_W, so LSB-first byte order is simply the flat byte order of the buffer.
    always_comb begin
        pay_idx  = idx_q - HDR_LEN;
        cur_byte = 8'(snap_q >> {pay_idx, 3'b000});
        if (idx_q < HDR_LEN) begin
            case (idx_q[1:0])
                2'd0:    cur_byte = 8'hA5;
                2'd1:    cur_byte = 8'h5A;
                2'd2:    cur_byte = 8'(N_CH);
                default: cur_byte = seq_q;
            endcase
        end
`ifdef FRAME_CSUM_EN
        if (idx_q == LAST_IDX) cur_byte = csum_q;
`endif
    end

    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        idx_d     = idx_q;
        tx_data_d = tx_data_q;
        seq_d     = seq_q;
        busy_d    = busy_q;
        cont_d    = cont_q;
        pend_d    = pend_q;
`ifdef FRAME_CSUM_EN
        csum_d    = csum_q;
`endif
        if (RX_VALID) begin
            if (RX_DATA == CMD_CONT)      cont_d = 1'b1;
            else if (RX_DATA == CMD_STOP) cont_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (pend_q || cont_q) begin
                    state_d = S_LATCH;
                    pend_d  = 1'b0;
                end
            end
            S_LATCH: begin
                snap_d  = DATA_IN;
                seq_d   = seq_q + 8'd1;
                busy_d  = 1'b1;
                idx_d   = '0;
`ifdef FRAME_CSUM_EN
                csum_d  = '0;
`endif
                state_d = S_LOAD;
            end
            S_LOAD: begin
                tx_data_d = cur_byte;
`ifdef FRAME_CSUM_EN
                if (idx_q >= HDR_LEN && idx_q != LAST_IDX) csum_d = csum_q + cur_byte;
`endif
                state_d = S_REQ;
            end
            S_REQ:  state_d = S_GAP;
            S_GAP:  state_d = S_WAIT;
            S_WAIT: begin
                if (TX_IDLE) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A snap strobe arriving as the latch is entered still books one more frame.
        if (RX_VALID && RX_DATA == CMD_SNAP) pend_d = 1'b1;
    end

    always_ff @(posedge CLK_50M or posedge RESET) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            snap_q    <= '0;
            idx_q     <= '0;
            tx_data_q <= '0;
            seq_q     <= '0;
            busy_q    <= 1'b0;
            cont_q    <= 1'b0;
            pend_q    <= 1'b0;
`ifdef FRAME_CSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            idx_q     <= idx_d;
            tx_data_q <= tx_data_d;
            seq_q     <= seq_d;
            busy_q    <= busy_d;
            cont_q    <= cont_d;
            pend_q    <= pend_d;
`ifdef FRAME_CSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    assign TX_DATA   = tx_data_q;
    assign TX_REQ    = (state_q == S_REQ);
    assign BUSY      = busy_q;
    assign CONT_MODE = cont_q;
    assign FRAME_SEQ = seq_q;

endmodule

// File: tb/tb_multi_ch_frame_tx.sv
// Scoreboard bench for multi_ch_frame_tx: default 16x16 instance plus a 3x24 instance (checksum byte when FRAME_CSUM_EN).
module tb_multi_ch_frame_tx;
    localparam int N1 = 16, W1 = 16, N2 = 3, W2 = 24;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic                 rst, rst2;
    logic [N1*W1-1:0]     din1;
    logic [7:0]           rxd1, txd1, seq1;
    logic                 rxv1, txr1, busy1, cont1;
    logic                 idle1 = 1'b1;
    logic [N2*W2-1:0]     din2;
    logic [7:0]           rxd2, txd2, seq2;
    logic                 rxv2, txr2, busy2, cont2;
    logic                 idle2 = 1'b1;

    multi_ch_frame_tx dut1 (
        .CLK_50M(clk), .RESET(rst), .DATA_IN(din1), .RX_DATA(rxd1), .RX_VALID(rxv1),
        .TX_DATA(txd1), .TX_REQ(txr1), .TX_IDLE(idle1), .BUSY(busy1),
        .CONT_MODE(cont1), .FRAME_SEQ(seq1)
    );

    multi_ch_frame_tx #(.N_CH(N2), .DATA_W(W2)) dut2 (
        .CLK_50M(clk), .RESET(rst2), .DATA_IN(din2), .RX_DATA(rxd2), .RX_VALID(rxv2),
        .TX_DATA(txd2), .TX_REQ(txr2), .TX_IDLE(idle2), .BUSY(busy2),
        .CONT_MODE(cont2), .FRAME_SEQ(seq2)
    );

    int n_tests = 0, n_fail = 0;
    int req1_cnt = 0;
    logic [7:0] q1[$], q2[$];
    logic [7:0] e1, e2;
    int cnt1 = 0, cnt2 = 0;
    bit hold1 = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Transmitter models: drop idle on a request, hold it low a few cycles (or while hold1 is set).
    always @(negedge clk) begin
        if (rst) begin
            idle1 = 1'b1; cnt1 = 0;
        end else if (txr1) begin
            idle1 = 1'b0; cnt1 = 2;
        end else if (cnt1 > 0) begin
            cnt1--;
        end else if (!hold1) begin
            idle1 = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst2) begin
            idle2 = 1'b1; cnt2 = 0;
        end else if (txr2) begin
            idle2 = 1'b0; cnt2 = 2;
        end else if (cnt2 > 0) begin
            cnt2--;
        end else begin
            idle2 = 1'b1;
        end
    end

    // Monitors: every TX_REQ must match the next expected byte.
    always @(negedge clk) begin
        if (txr1 === 1'b1) begin
            req1_cnt++;
            if (q1.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL tx1_extra: got byte %02h, expected no request", txd1);
            end else begin
                e1 = q1.pop_front();
                chk("tx1_byte", 64'(txd1), 64'(e1));
            end
        end
    end

    always @(negedge clk) begin
        if (txr2 === 1'b1) begin
            if (q2.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL tx2_extra: got byte %02h, expected no request", txd2);
            end else begin
                e2 = q2.pop_front();
                chk("tx2_byte", 64'(txd2), 64'(e2));
            end
        end
    end

    task automatic push1(input logic [7:0] seq, input logic [N1*W1-1:0] d);
        logic [W1-1:0] w;
        logic [7:0]    b;
`ifdef FRAME_CSUM_EN
        logic [7:0]    sum = '0;
`endif
        q1.push_back(8'hA5); q1.push_back(8'h5A); q1.push_back(8'h10); q1.push_back(seq);
        for (int ch = 0; ch < N1; ch++) begin
            w = d[ch*W1 +: W1];
            for (int k = 0; k < W1/8; k++) begin
                b = 8'(w >> (8*k));
                q1.push_back(b);
`ifdef FRAME_CSUM_EN
                sum += b;
`endif
            end
        end
`ifdef FRAME_CSUM_EN
        q1.push_back(sum);
`endif
    endtask

    task automatic push2(input logic [7:0] seq);
        q2.push_back(8'hA5); q2.push_back(8'h5A); q2.push_back(8'h03); q2.push_back(seq);
        q2.push_back(8'h01); q2.push_back(8'h00); q2.push_back(8'h00);
        q2.push_back(8'h02); q2.push_back(8'h00); q2.push_back(8'h00);
        q2.push_back(8'h03); q2.push_back(8'h00); q2.push_back(8'h00);
`ifdef FRAME_CSUM_EN
        q2.push_back(8'h06);
`endif
    endtask

    task automatic send1(input logic [7:0] b);
        @(negedge clk); rxd1 = b; rxv1 = 1'b1;
        @(negedge clk); rxv1 = 1'b0;
    endtask

    task automatic send2(input logic [7:0] b);
        @(negedge clk); rxd2 = b; rxv2 = 1'b1;
        @(negedge clk); rxv2 = 1'b0;
    endtask

    task automatic wait_busy1(input logic lvl, input int bound, input string nm);
        int n = 0;
        while (busy1 !== lvl && n < bound) begin @(negedge clk); n++; end
        chk(nm, 64'(n < bound), 64'd1);
    endtask

    task automatic wait_req1(input int cnt, input int bound);
        int seen = 0, n = 0;
        while (seen < cnt && n < bound) begin
            @(negedge clk); n++;
            if (txr1) seen++;
        end
        chk("req_wait_timeout", 64'(n < bound), 64'd1);
    endtask

    task automatic wait_seq2(input logic [7:0] v, input int bound);
        int n = 0;
        while (seq2 !== v && n < bound) begin @(negedge clk); n++; end
        chk("seq2_wait_timeout", 64'(n < bound), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int lat, gap, bad, rsave;
        logic [7:0] saved;
        rst = 1'b1; rst2 = 1'b1;
        rxv1 = 1'b0; rxd1 = '0; rxv2 = 1'b0; rxd2 = '0;
        for (int ch = 0; ch < N1; ch++) din1[ch*W1 +: W1] = {8'(ch), 8'(8'hC0 + ch)};
        din1[0 +: W1]    = 16'h1234;
        din1[15*W1 +: W1] = 16'hBEEF;
        din2 = {24'h000003, 24'h000002, 24'h000001};
        #35;
        chk("rst_tx_data", 64'(txd1), 64'h0);
        chk("rst_tx_req", 64'(txr1), 64'h0);
        chk("rst_busy", 64'(busy1), 64'h0);
        chk("rst_cont", 64'(cont1), 64'h0);
        chk("rst_seq", 64'(seq1), 64'h0);
        @(negedge clk); rst = 1'b0; rst2 = 1'b0;
        repeat (3) @(negedge clk);

        // Single snapshot, latency, and snapshot isolation from DATA_IN changes
        push1(8'h01, din1);
        @(negedge clk); rxd1 = 8'hFF; rxv1 = 1'b1;
        @(negedge clk); rxv1 = 1'b0; lat = 1;
        while (!txr1 && lat < 20) begin @(negedge clk); lat++; end
        chk("cmd_to_req_latency", 64'(lat), 64'd4);
        chk("busy_in_frame", 64'(busy1), 64'd1);
        din1 = ~din1;
        wait_busy1(1'b0, 2000, "snap_done_timeout");
        chk("snap_seq", 64'(seq1), 64'h01);
        chk("snap_drained", 64'(q1.size()), 64'd0);

        // Continuous mode, stop mid-frame
        for (int s = 2; s <= 5; s++) push1(8'(s), din1);
        send1(8'hFE);
        chk("cont_set", 64'(cont1), 64'd1);
        wait_busy1(1'b1, 100, "cont_f2_start");
        wait_busy1(1'b0, 2000, "cont_f2_done");
        gap = 0;
        while (busy1 == 1'b0 && gap < 10) begin @(negedge clk); gap++; end
        chk("cont_gap", 64'(gap), 64'd2);
        wait_busy1(1'b0, 2000, "cont_f3_done");
        wait_busy1(1'b1, 100, "cont_f4_start");
        wait_busy1(1'b0, 2000, "cont_f4_done");
        wait_busy1(1'b1, 100, "cont_f5_start");
        wait_req1(10, 500);
        send1(8'h00);
        chk("cont_cleared", 64'(cont1), 64'd0);
        wait_busy1(1'b0, 2000, "cont_f5_done");
        repeat (60) @(negedge clk);
        chk("cont_no_extra_frame", 64'(q1.size()), 64'd0);
        chk("cont_final_seq", 64'(seq1), 64'h05);
        chk("cont_busy_low", 64'(busy1), 64'd0);

        // Transmitter stalls after the 5th request
        push1(8'h06, din1);
        send1(8'hFF);
        wait_req1(5, 500);
        hold1 = 1'b1;
        @(negedge clk);
        saved = txd1; bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (txr1 || txd1 !== saved) bad++;
        end
        chk("stall_no_req_data_stable", 64'(bad), 64'd0);
        chk("stall_busy", 64'(busy1), 64'd1);
        hold1 = 1'b0;
        wait_busy1(1'b0, 2000, "stall_done");
        chk("stall_drained", 64'(q1.size()), 64'd0);

        // Reset during byte 10
        push1(8'h07, din1);
        send1(8'hFF);
        wait_req1(10, 500);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_tx_data", 64'(txd1), 64'h0);
        chk("midrst_tx_req", 64'(txr1), 64'h0);
        chk("midrst_busy", 64'(busy1), 64'h0);
        chk("midrst_cont", 64'(cont1), 64'h0);
        chk("midrst_seq", 64'(seq1), 64'h0);
        q1.delete();
        @(negedge clk); rst = 1'b0;
        rsave = req1_cnt;
        repeat (50) @(negedge clk);
        chk("midrst_no_req", 64'(req1_cnt - rsave), 64'd0);
        push1(8'h01, din1);
        send1(8'hFF);
        wait_busy1(1'b1, 100, "resnap_start");
        wait_busy1(1'b0, 2000, "resnap_done");
        chk("resnap_seq", 64'(seq1), 64'h01);

        // Three snap commands while busy give two frames
        push1(8'h02, din1);
        push1(8'h03, din1);
        send1(8'hFF);
        wait_busy1(1'b1, 100, "multi_start");
        send1(8'hFF);
        send1(8'hFF);
        wait_busy1(1'b0, 2000, "multi_f1_done");
        wait_busy1(1'b1, 100, "multi_f2_start");
        wait_busy1(1'b0, 2000, "multi_f2_done");
        repeat (60) @(negedge clk);
        chk("multi_two_frames", 64'(q1.size()), 64'd0);
        chk("multi_seq", 64'(seq1), 64'h03);
        chk("multi_busy_low", 64'(busy1), 64'd0);

        // 3x24 instance: continuous run through the FRAME_SEQ wrap
        for (int s = 1; s <= 256; s++) push2(8'(s));
        send2(8'hFE);
        wait_seq2(8'hFF, 30000);
        wait_seq2(8'h00, 500);
        send2(8'h00);
        begin
            int n = 0;
            while (busy2 !== 1'b0 && n < 500) begin @(negedge clk); n++; end
            chk("wrap_done_timeout", 64'(n < 500), 64'd1);
        end
        repeat (60) @(negedge clk);
        chk("wrap_all_frames", 64'(q2.size()), 64'd0);
        chk("wrap_seq", 64'(seq2), 64'h00);
        chk("wrap_cont_off", 64'(cont2), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
